alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_timeout_cnt.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: state encoding,
// unit-select codes and the default timeout.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } alu_state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 7;

  // One-hot enable vector ordered {arith, logic, cmp, shift}
  function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    oh = '0;
    case (sel)
      UNIT_ARITH: oh = 4'b1000;
      UNIT_LOGIC: oh = 4'b0100;
      UNIT_CMP:   oh = 4'b0010;
      UNIT_SHIFT: oh = 4'b0001;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_timeout_cnt.sv
// WAIT-cycle counter: counts enabled cycles after a clear and flags the
// cycle in which the count reaches TIMEOUT.
module alu_timeout_cnt
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

  logic [3:0] cnt;

  // Count enabled cycles; clear dominates enable
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Expires on the enabled cycle that brings the count up to TIMEOUT
  always_comb begin
    expired = en && (cnt == LAST);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts a command, pulses one unit enable, waits
// for the unit flag (or a timeout) and holds the result until consumed.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Cmd_Valid,
  output logic                    Cmd_Ready,
  input  logic [3:0]              Cmd_Fun,
  input  logic signed [WIDTH-1:0] Cmd_A,
  input  logic signed [WIDTH-1:0] Cmd_B,
  output logic signed [WIDTH-1:0] A,
  output logic signed [WIDTH-1:0] B,
  output logic [1:0]              ALU_FUN,
  output logic                    Arith_Enable,
  output logic                    Logic_Enable,
  output logic                    CMP_Enable,
  output logic                    Shift_Enable,
  input  logic [WIDTH-1:0]        Unit_OUT,
  input  logic                    Unit_Flag,
  output logic                    Res_Valid,
  input  logic                    Res_Ready,
  output logic [WIDTH-1:0]        Res_Data,
  output logic                    Res_Err,
  output logic                    Busy
);

  alu_state_t state;
  logic [3:0] en_q;
  logic       cnt_clr;
  logic       cnt_en;
  logic       expired;

  assign {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable} = en_q;

  // Counter runs only across WAIT cycles that see no unit flag
  always_comb begin
    cnt_clr = (state != ST_WAIT);
    cnt_en  = (state == ST_WAIT) && !Unit_Flag;
  end

  alu_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  // Controller FSM with all outputs registered
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      Cmd_Ready <= 1'b0;
      A         <= '0;
      B         <= '0;
      ALU_FUN   <= '0;
      en_q      <= '0;
      Res_Valid <= 1'b0;
      Res_Data  <= '0;
      Res_Err   <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Ready rises one cycle after reset or a completed handshake
          Cmd_Ready <= 1'b1;
          if (Cmd_Ready && Cmd_Valid) begin
            state     <= ST_ISSUE;
            Cmd_Ready <= 1'b0;
            Busy      <= 1'b1;
            A         <= Cmd_A;
            B         <= Cmd_B;
            ALU_FUN   <= Cmd_Fun[1:0];
            en_q      <= unit_onehot(Cmd_Fun[3:2]);
          end
        end
        ST_ISSUE: begin
          en_q  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Unit_Flag) begin
            Res_Data  <= Unit_OUT;
            Res_Err   <= 1'b0;
            Res_Valid <= 1'b1;
            A         <= '0;
            B         <= '0;
            ALU_FUN   <= '0;
            state     <= ST_HOLD;
          end else if (expired) begin
            Res_Data  <= '0;
            Res_Err   <= 1'b1;
            Res_Valid <= 1'b1;
            A         <= '0;
            B         <= '0;
            ALU_FUN   <= '0;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (Res_Ready) begin
            Res_Valid <= 1'b0;
            Busy      <= 1'b0;
            Cmd_Ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
